// File: rtl/reg_arb_pkg.sv
// Shared types for the two-host register access arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The request struct is sized by ARB_REG_W / ARB_ADDR_W; the top-level
// REG_W / ADDR_W parameters default to these and must track them.
package reg_arb_pkg;

    localparam int NUM_HOSTS  = 2;
    localparam int ARB_REG_W  = 8;
    localparam int ARB_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    typedef logic host_idx_t;

    typedef struct packed {
        logic                  wr_rdn;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_REG_W-1:0]  wdata;
    } arb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with its own pointer.
// Latency: grant is combinational from i_req; pointer updates on i_advance.
// Backpressure: none; the caller decides when a grant is consumed.
//
// Ports: i_req (one bit per host), i_advance (grant taken this cycle),
//        o_grant (one-hot, zero when nobody requests), o_gidx (winner index).
module rr_arbiter2
    import reg_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_HOSTS-1:0] i_req,
    input  logic                 i_advance,
    output logic [NUM_HOSTS-1:0] o_grant,
    output host_idx_t            o_gidx
);

    host_idx_t r_ptr;
    host_idx_t w_gidx;

    // The pointed-at host wins a tie; a lone requester wins regardless.
    always_comb begin
        w_gidx  = r_ptr;
        if (!i_req[r_ptr] && i_req[~r_ptr]) begin
            w_gidx = ~r_ptr;
        end
        o_grant = '0;
        if (|i_req) begin
            o_grant[w_gidx] = 1'b1;
        end
    end

    assign o_gidx = w_gidx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~w_gidx;
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbitrates SPI (host 0) and I2C (host 1) register accesses onto one bank port.
// Latency: 4 cycles request->rsp for in-range accesses, 3 for range errors.
// Backpressure: one-deep slot per host; busy while full, ovf pulse on a drop.
//
// Ports: clk/rst (sync, active high); per host hN_req/wr_rdn/addr/wdata in,
//        hN_busy/ovf/rsp/err/rdata out; bank_req/wr_rdn/addr/wdata out,
//        bank_rdata in (valid one cycle after bank_req).
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int REG_W    = ARB_REG_W,
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int NUM_REGS = 16,
    parameter int BANK_AW  = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               h0_req,
    input  logic               h0_wr_rdn,
    input  logic [ADDR_W-1:0]  h0_addr,
    input  logic [REG_W-1:0]   h0_wdata,
    output logic               h0_busy,
    output logic               h0_ovf,
    output logic               h0_rsp,
    output logic               h0_err,
    output logic [REG_W-1:0]   h0_rdata,
    input  logic               h1_req,
    input  logic               h1_wr_rdn,
    input  logic [ADDR_W-1:0]  h1_addr,
    input  logic [REG_W-1:0]   h1_wdata,
    output logic               h1_busy,
    output logic               h1_ovf,
    output logic               h1_rsp,
    output logic               h1_err,
    output logic [REG_W-1:0]   h1_rdata,
    output logic               bank_req,
    output logic               bank_wr_rdn,
    output logic [BANK_AW-1:0] bank_addr,
    output logic [REG_W-1:0]   bank_wdata,
    input  logic [REG_W-1:0]   bank_rdata
);

    // Host requests are flopped at the pins first; slot acceptance works on
    // the flopped copy, which places busy one cycle after the request edge.
    logic [NUM_HOSTS-1:0] r_in_vld;
    arb_req_t             r_in_req   [NUM_HOSTS];
    logic [NUM_HOSTS-1:0] r_slot_vld;
    arb_req_t             r_slot     [NUM_HOSTS];
    logic [NUM_HOSTS-1:0] r_ovf;
    logic [NUM_HOSTS-1:0] r_rsp;
    logic [NUM_HOSTS-1:0] r_err;
    logic [REG_W-1:0]     r_rdata    [NUM_HOSTS];

    arb_state_t           r_state;
    host_idx_t            r_win;
    logic                 r_iss_err;
    logic                 r_bank_req;
    logic                 r_bank_wr_rdn;
    logic [BANK_AW-1:0]   r_bank_addr;
    logic [REG_W-1:0]     r_bank_wdata;

    logic [NUM_HOSTS-1:0] w_req;
    arb_req_t             w_req_dat  [NUM_HOSTS];
    logic [NUM_HOSTS-1:0] w_grant;
    host_idx_t            w_gidx;
    logic                 w_iss_load;
    logic [NUM_HOSTS-1:0] w_clr;
    arb_req_t             w_sel;
    logic                 w_in_range;

    always_comb begin
        w_req        = {h1_req, h0_req};
        w_req_dat[0] = '{wr_rdn: h0_wr_rdn, addr: h0_addr, wdata: h0_wdata};
        w_req_dat[1] = '{wr_rdn: h1_wr_rdn, addr: h1_addr, wdata: h1_wdata};
    end

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req     (r_slot_vld),
        .i_advance (w_iss_load),
        .o_grant   (w_grant),
        .o_gidx    (w_gidx)
    );

    assign w_iss_load = (r_state == IDLE) && (|r_slot_vld);
    assign w_clr      = w_iss_load ? w_grant : '0;
    assign w_sel      = r_slot[w_gidx];
    // Range check on the full host address so aliases above NUM_REGS error out.
    assign w_in_range = (32'(w_sel.addr) < NUM_REGS);

    // Pending slots. A flopped request arriving on the cycle its slot is
    // emptied into the issue register is accepted rather than dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_vld   <= '0;
            r_slot_vld <= '0;
            r_ovf      <= '0;
            for (int i = 0; i < NUM_HOSTS; i++) begin
                r_in_req[i] <= '0;
                r_slot[i]   <= '0;
            end
        end else begin
            r_in_vld <= w_req;
            for (int i = 0; i < NUM_HOSTS; i++) begin
                r_in_req[i] <= w_req_dat[i];
                r_ovf[i]    <= 1'b0;
                if (r_in_vld[i] && (!r_slot_vld[i] || w_clr[i])) begin
                    r_slot_vld[i] <= 1'b1;
                    r_slot[i]     <= r_in_req[i];
                end else if (r_in_vld[i]) begin
                    r_ovf[i] <= 1'b1;
                end else if (w_clr[i]) begin
                    r_slot_vld[i] <= 1'b0;
                end
            end
        end
    end

    // Access FSM. The bank_* flops double as the issue register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_win         <= 1'b0;
            r_iss_err     <= 1'b0;
            r_bank_req    <= 1'b0;
            r_bank_wr_rdn <= 1'b0;
            r_bank_addr   <= '0;
            r_bank_wdata  <= '0;
            r_rsp         <= '0;
            r_err         <= '0;
            for (int i = 0; i < NUM_HOSTS; i++) begin
                r_rdata[i] <= '0;
            end
        end else begin
            r_bank_req <= 1'b0;
            r_rsp      <= '0;
            r_err      <= '0;
            case (r_state)
                IDLE: begin
                    if (w_iss_load) begin
                        r_win         <= w_gidx;
                        r_bank_wr_rdn <= w_sel.wr_rdn;
                        r_bank_addr   <= w_sel.addr[BANK_AW-1:0];
                        r_bank_wdata  <= w_sel.wdata;
                        r_iss_err     <= !w_in_range;
                        if (w_in_range) begin
                            r_bank_req <= 1'b1;
                            r_state    <= ISSUE;
                        end else begin
                            r_state    <= CAPTURE;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    if (r_iss_err) begin
                        r_rdata[r_win] <= '0;
                    end else if (!r_bank_wr_rdn) begin
                        r_rdata[r_win] <= bank_rdata;
                    end
                    r_rsp[r_win] <= 1'b1;
                    r_err[r_win] <= r_iss_err;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign h0_busy     = r_slot_vld[0];
    assign h1_busy     = r_slot_vld[1];
    assign h0_ovf      = r_ovf[0];
    assign h1_ovf      = r_ovf[1];
    assign h0_rsp      = r_rsp[0];
    assign h1_rsp      = r_rsp[1];
    assign h0_err      = r_err[0];
    assign h1_err      = r_err[1];
    assign h0_rdata    = r_rdata[0];
    assign h1_rdata    = r_rdata[1];
    assign bank_req    = r_bank_req;
    assign bank_wr_rdn = r_bank_wr_rdn;
    assign bank_addr   = r_bank_addr;
    assign bank_wdata  = r_bank_wdata;

endmodule
